// File: rtl/fb_scanout_if.sv
// Scanout reader bus: SRAM read port plus the pixel stream toward the display.
// master is the reader side, slave is the SRAM/display side.
interface fb_scanout_if #(
    parameter int WIDTH_BITS   = 9,
    parameter int HEIGHT_BITS  = 8,
    parameter int CHANNEL_BITS = 8
);
    logic                              enable_i;
    logic                              buffer_select_i;
    logic                              sram_gnt_i;
    logic                              sram_rd_o;
    logic [WIDTH_BITS+HEIGHT_BITS:0]   sram_addr_o;
    logic [3*CHANNEL_BITS-1:0]         sram_data_i;
    logic                              pixel_valid_o;
    logic                              pixel_ready_i;
    logic [3*CHANNEL_BITS-1:0]         pixel_o;
    logic                              sof_o;
    logic                              eol_o;
    logic                              frame_done_o;
    logic                              busy_o;

    modport master (
        input  enable_i, buffer_select_i, sram_gnt_i, sram_data_i, pixel_ready_i,
        output sram_rd_o, sram_addr_o, pixel_valid_o, pixel_o,
        output sof_o, eol_o, frame_done_o, busy_o
    );

    modport slave (
        output enable_i, buffer_select_i, sram_gnt_i, sram_data_i, pixel_ready_i,
        input  sram_rd_o, sram_addr_o, pixel_valid_o, pixel_o,
        input  sof_o, eol_o, frame_done_o, busy_o
    );
endinterface

// File: rtl/fb_scanout_reader.sv
// Framebuffer scanout reader: scans the front buffer row-major through the
// shared SRAM port and streams pixels with sof/eol markers to the display.
module fb_scanout_reader #(
    parameter int WIDTH        = 320,
    parameter int HEIGHT       = 240,
    parameter int WIDTH_BITS   = 9,
    parameter int HEIGHT_BITS  = 8,
    parameter int CHANNEL_BITS = 8,
    parameter int READ_LATENCY = 2,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        rst,
    fb_scanout_if.master bus
);
    localparam int DW = 3 * CHANNEL_BITS;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAIN
    } state_t;

    state_t                  state;
    logic [WIDTH_BITS-1:0]   x;
    logic [HEIGHT_BITS-1:0]  y;
    logic                    front_buf;
    logic [CW-1:0]           inflight;
    logic [CW-1:0]           fifo_count;
    logic [AW-1:0]           wr_ptr;
    logic [AW-1:0]           rd_ptr;
    logic [DW-1:0]           fifo_data [FIFO_DEPTH];
    logic [2:0]              fifo_tag  [FIFO_DEPTH];
    logic [READ_LATENCY-1:0] pipe_vld;
    logic [READ_LATENCY-1:0] pipe_sof;
    logic [READ_LATENCY-1:0] pipe_eol;
    logic [READ_LATENCY-1:0] pipe_last;

    logic x_end;
    logic y_end;
    logic credit_ok;
    logic issue;
    logic push;
    logic pop;
    logic head_valid;
    logic frame_empty;

    assign x_end       = (x == WIDTH_BITS'(WIDTH - 1));
    assign y_end       = (y == HEIGHT_BITS'(HEIGHT - 1));
    assign credit_ok   = ({1'b0, fifo_count} + {1'b0, inflight}) < (CW+1)'(FIFO_DEPTH);
    assign issue       = (state == FETCH) & bus.sram_gnt_i & credit_ok;
    assign push        = pipe_vld[READ_LATENCY-1];
    assign head_valid  = (fifo_count != '0);
    assign pop         = head_valid & bus.pixel_ready_i;
    assign frame_empty = (inflight == '0) & (fifo_count == '0);

    assign bus.sram_rd_o     = issue;
    assign bus.sram_addr_o   = {front_buf, y, x};
    assign bus.pixel_valid_o = head_valid;
    assign bus.pixel_o       = head_valid ? fifo_data[rd_ptr] : '0;
    assign bus.sof_o         = head_valid & fifo_tag[rd_ptr][2];
    assign bus.eol_o         = head_valid & fifo_tag[rd_ptr][1];
    assign bus.frame_done_o  = pop & fifo_tag[rd_ptr][0];
    assign bus.busy_o        = (state != IDLE);

    // Frame sequencer: latches the front buffer at frame start and walks x/y per issued read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            x         <= '0;
            y         <= '0;
            front_buf <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.enable_i) begin
                        state     <= FETCH;
                        front_buf <= ~bus.buffer_select_i;
                        x         <= '0;
                        y         <= '0;
                    end
                end
                FETCH: begin
                    if (issue) begin
                        if (x_end) begin
                            x <= '0;
                            if (y_end) begin
                                y     <= '0;
                                state <= DRAIN;
                            end else begin
                                y <= y + 1'b1;
                            end
                        end else begin
                            x <= x + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (frame_empty) begin
                        if (bus.enable_i) begin
                            state     <= FETCH;
                            front_buf <= ~bus.buffer_select_i;
                            x         <= '0;
                            y         <= '0;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Tag pipe: travels with each read so returning data knows its position.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe_vld  <= '0;
            pipe_sof  <= '0;
            pipe_eol  <= '0;
            pipe_last <= '0;
        end else begin
            for (int i = READ_LATENCY - 1; i > 0; i--) begin
                pipe_vld[i]  <= pipe_vld[i-1];
                pipe_sof[i]  <= pipe_sof[i-1];
                pipe_eol[i]  <= pipe_eol[i-1];
                pipe_last[i] <= pipe_last[i-1];
            end
            pipe_vld[0]  <= issue;
            pipe_sof[0]  <= issue & (x == '0) & (y == '0);
            pipe_eol[0]  <= issue & x_end;
            pipe_last[0] <= issue & x_end & y_end;
        end
    end

    // Reads in flight between strobe and data return; feeds the credit check.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inflight <= '0;
        end else begin
            inflight <= inflight + CW'(issue) - CW'(push);
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            fifo_count <= fifo_count + CW'(push) - CW'(pop);
        end
    end

    // FIFO storage; contents are only visible through the occupancy-gated head.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data[wr_ptr] <= bus.sram_data_i;
            fifo_tag[wr_ptr]  <= {pipe_sof[READ_LATENCY-1],
                                  pipe_eol[READ_LATENCY-1],
                                  pipe_last[READ_LATENCY-1]};
        end
    end

    // The credit check must keep a push from ever landing in a full FIFO.
    always_ff @(posedge clk) begin
        if (!rst && push && !pop) begin
            assert (fifo_count < CW'(FIFO_DEPTH));
        end
    end
endmodule

// File: tb/tb_fb_scanout_reader.sv
// Directed bench for fb_scanout_reader on a 4x2 frame with an SRAM model
// that returns the read address as the pixel colour.
module tb_fb_scanout_reader;
    localparam int W  = 4;
    localparam int H  = 2;
    localparam int WB = 2;
    localparam int HB = 1;
    localparam int CB = 8;
    localparam int RL = 2;
    localparam int FD = 4;

    logic tb_clk;
    logic rst;
    int   checks;
    int   errors;
    int   fd_cnt;
    logic [3:0]  rd_log[$];
    logic [25:0] pix_log[$];
    logic [23:0] rpipe[RL];

    fb_scanout_if #(.WIDTH_BITS(WB), .HEIGHT_BITS(HB), .CHANNEL_BITS(CB)) bus ();

    fb_scanout_reader #(
        .WIDTH(W), .HEIGHT(H), .WIDTH_BITS(WB), .HEIGHT_BITS(HB),
        .CHANNEL_BITS(CB), .READ_LATENCY(RL), .FIFO_DEPTH(FD)
    ) dut (
        .clk(tb_clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        logic       bsel;
        logic [3:0] gp;
        logic [3:0] rp;
        logic       fb;
    } vec_t;

    vec_t vecs[5];

    initial begin
        tb_clk = 1'b0;
        forever #5 tb_clk = ~tb_clk;
    end

    // SRAM model: data is the address, READ_LATENCY cycles after the strobe.
    always @(posedge tb_clk) begin
        for (int i = RL - 1; i > 0; i--) rpipe[i] <= rpipe[i-1];
        rpipe[0] <= bus.sram_rd_o ? {20'd0, bus.sram_addr_o} : 24'hBADBAD;
    end
    assign bus.sram_data_i = rpipe[RL-1];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Monitor: logs reads and pops, checks grant, credit, stall hold and frame_done.
    initial begin
        int          occ;
        logic        prev_stall;
        logic [25:0] prev_head;
        logic [25:0] head;
        occ = 0;
        prev_stall = 1'b0;
        prev_head = '0;
        forever begin
            @(negedge tb_clk);
            if (rst) begin
                occ = 0;
                prev_stall = 1'b0;
            end else begin
                head = {bus.sof_o, bus.eol_o, bus.pixel_o};
                if (bus.sram_rd_o) begin
                    check("rd_gnt", 32'(bus.sram_gnt_i), 1);
                    check("credit", 32'(occ < FD), 1);
                    rd_log.push_back(bus.sram_addr_o);
                    occ++;
                end
                if (prev_stall && bus.pixel_valid_o) check("stall_hold", 32'(head), 32'(prev_head));
                if (bus.pixel_valid_o && bus.pixel_ready_i) begin
                    pix_log.push_back(head);
                    occ--;
                end
                if (bus.frame_done_o) begin
                    fd_cnt++;
                    check("fd_last",
                          (bus.pixel_valid_o && bus.pixel_ready_i) ? 32'(bus.pixel_o[2:0]) : 32'hFF, 7);
                end
                prev_stall = bus.pixel_valid_o && !bus.pixel_ready_i;
                prev_head = head;
            end
        end
    end

    task automatic clear_logs();
        rd_log.delete();
        pix_log.delete();
        fd_cnt = 0;
    endtask

    task automatic pulse_enable();
        @(posedge tb_clk); #1;
        bus.enable_i = 1'b1;
        @(posedge tb_clk); #1;
        bus.enable_i = 1'b0;
    endtask

    task automatic wait_reads(input int n);
        int cyc;
        cyc = 0;
        while (rd_log.size() < n && cyc < 200) begin
            @(posedge tb_clk); #1;
            cyc++;
        end
        check("wait_reads", 32'(rd_log.size() >= n), 1);
    endtask

    task automatic wait_idle(input logic [3:0] gp, input logic [3:0] rp);
        int cyc;
        cyc = 0;
        while (bus.busy_o && cyc < 500) begin
            @(posedge tb_clk); #1;
            bus.sram_gnt_i    = gp[cyc % 4];
            bus.pixel_ready_i = rp[cyc % 4];
            cyc++;
        end
        check("idle_timeout", 32'(bus.busy_o), 0);
        bus.sram_gnt_i    = 1'b1;
        bus.pixel_ready_i = 1'b1;
    endtask

    task automatic compare_frames(input int nf, input logic fb0, input logic fb1);
        logic        fb;
        logic [3:0]  ea;
        logic [25:0] eh;
        int          j;
        check("n_reads", rd_log.size(), 8 * nf);
        check("n_pixels", pix_log.size(), 8 * nf);
        check("fd_count", fd_cnt, nf);
        check("busy_end", 32'(bus.busy_o), 0);
        for (int i = 0; i < 8 * nf; i++) begin
            j  = i % 8;
            fb = (i < 8) ? fb0 : fb1;
            ea = {fb, 3'(j)};
            eh = '0;
            eh[25]  = (j == 0);
            eh[24]  = (j % 4 == 3);
            eh[3:0] = ea;
            if (i < rd_log.size()) check("rd_addr", 32'(rd_log[i]), 32'(ea));
            if (i < pix_log.size()) check("pixel", 32'(pix_log[i]), 32'(eh));
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        fd_cnt = 0;
        vecs[0] = '{1'b0, 4'b1111, 4'b1111, 1'b1};
        vecs[1] = '{1'b1, 4'b1111, 4'b1111, 1'b0};
        vecs[2] = '{1'b0, 4'b1001, 4'b1111, 1'b1};
        vecs[3] = '{1'b1, 4'b1111, 4'b0101, 1'b0};
        vecs[4] = '{1'b0, 4'b1001, 4'b0011, 1'b1};

        rst = 1'b1;
        bus.enable_i        = 1'b0;
        bus.buffer_select_i = 1'b0;
        bus.sram_gnt_i      = 1'b1;
        bus.pixel_ready_i   = 1'b1;
        #3;
        check("rst_rd", 32'(bus.sram_rd_o), 0);
        check("rst_addr", 32'(bus.sram_addr_o), 0);
        check("rst_valid", 32'(bus.pixel_valid_o), 0);
        check("rst_pixel", 32'(bus.pixel_o), 0);
        check("rst_flags", {29'd0, bus.sof_o, bus.eol_o, bus.frame_done_o}, 0);
        check("rst_busy", 32'(bus.busy_o), 0);
        repeat (2) @(posedge tb_clk);
        #1 rst = 1'b0;

        for (int v = 0; v < 5; v++) begin
            clear_logs();
            bus.buffer_select_i = vecs[v].bsel;
            pulse_enable();
            wait_idle(vecs[v].gp, vecs[v].rp);
            compare_frames(1, vecs[v].fb, vecs[v].fb);
        end

        clear_logs();
        bus.buffer_select_i = 1'b1;
        pulse_enable();
        wait_reads(3);
        bus.pixel_ready_i = 1'b0;
        repeat (20) @(posedge tb_clk);
        #1;
        check("bp_outstanding", rd_log.size() - pix_log.size(), FD);
        check("bp_valid", 32'(bus.pixel_valid_o), 1);
        bus.pixel_ready_i = 1'b1;
        wait_idle(4'hF, 4'hF);
        compare_frames(1, 1'b0, 1'b0);

        clear_logs();
        bus.buffer_select_i = 1'b0;
        @(posedge tb_clk); #1;
        bus.enable_i = 1'b1;
        wait_reads(3);
        bus.buffer_select_i = 1'b1;
        wait_reads(10);
        bus.enable_i = 1'b0;
        wait_idle(4'hF, 4'hF);
        compare_frames(2, 1'b1, 1'b0);

        clear_logs();
        bus.buffer_select_i = 1'b0;
        @(posedge tb_clk); #1;
        bus.enable_i = 1'b1;
        wait_reads(2);
        bus.enable_i = 1'b0;
        wait_idle(4'hF, 4'hF);
        repeat (3) @(posedge tb_clk);
        #1;
        compare_frames(1, 1'b1, 1'b1);

        clear_logs();
        bus.buffer_select_i = 1'b1;
        pulse_enable();
        wait_reads(2);
        @(posedge tb_clk); #2;
        rst = 1'b1;
        #1;
        check("mrst_rd", 32'(bus.sram_rd_o), 0);
        check("mrst_addr", 32'(bus.sram_addr_o), 0);
        check("mrst_valid", 32'(bus.pixel_valid_o), 0);
        check("mrst_pixel", 32'(bus.pixel_o), 0);
        check("mrst_busy", 32'(bus.busy_o), 0);
        repeat (2) @(posedge tb_clk);
        #1 rst = 1'b0;
        repeat (6) @(posedge tb_clk);
        #1;
        check("mrst_dropped", 32'(bus.pixel_valid_o), 0);
        check("mrst_no_pix", pix_log.size(), 0);
        clear_logs();
        bus.buffer_select_i = 1'b0;
        pulse_enable();
        wait_idle(4'hF, 4'hF);
        compare_frames(1, 1'b1, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
